nand_gate_pipe: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit 2-input NAND.
- Applies a selectable bitwise gate function across NUM_IN operands of WIDTH bits each and produces one registered WIDTH-bit result.
- Uses a valid/ready handshake on both sides, with a one-entry skid buffer so full throughput is kept under backpressure.
- Sits between operand producers and downstream consumers in the gate-level datapath; also keeps a transaction counter for debug.

---
 rtl/nand_gate_pkg.sv | 43 ++++
 rtl/nand_gate_skid.sv | 43 ++++
 rtl/nand_gate_pipe.sv | 62 ++++++
 tb/tb_nand_gate_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nand_gate_pkg.sv
// Shared op codes and the per-bit gate reduction used by nand_gate_pipe.
// gate_reduce works on one bit column (bit b of every operand) at a time.
package nand_gate_pkg;
   localparam int OP_W   = 3;
   localparam int MAX_IN = 8;

   localparam logic [OP_W-1:0] OP_NAND = 3'd0;
   localparam logic [OP_W-1:0] OP_AND  = 3'd1;
   localparam logic [OP_W-1:0] OP_NOR  = 3'd2;
   localparam logic [OP_W-1:0] OP_OR   = 3'd3;
   localparam logic [OP_W-1:0] OP_XOR  = 3'd4;
   localparam logic [OP_W-1:0] OP_XNOR = 3'd5;
   localparam logic [OP_W-1:0] OP_NOT  = 3'd6;
   localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

   // Returns {err, result}; only the low n entries of bits take part.
   function automatic logic [1:0] gate_reduce(input logic [OP_W-1:0] op,
                                              input logic [MAX_IN-1:0] bits,
                                              input int n);
      logic r_and, r_or, r_xor, r;
      r_and = 1'b1;
      r_or  = 1'b0;
      r_xor = 1'b0;
      for (int k = 0; k < MAX_IN; k++) begin
         if (k < n) begin
            r_and = r_and & bits[k];
            r_or  = r_or  | bits[k];
            r_xor = r_xor ^ bits[k];
         end
      end
      case (op)
         OP_NAND: r = ~r_and;
         OP_AND:  r = r_and;
         OP_NOR:  r = ~r_or;
         OP_OR:   r = r_or;
         OP_XOR:  r = r_xor;
         OP_XNOR: r = ~r_xor;
         OP_NOT:  r = ~bits[0];
         default: r = ~r_and;
      endcase
      return {op == OP_RSVD, r};
   endfunction
endpackage

// File: rtl/nand_gate_skid.sv
// Output register plus one-entry skid buffer on a valid/ready channel.
// in_ready depends only on skid occupancy, so it never combinationally follows out_ready.
module nand_gate_skid #(
   parameter int DW = 9
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data
);
   logic          skid_valid;
   logic [DW-1:0] skid_data;

   assign in_ready = rst_n && !skid_valid;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_data   <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!out_valid || out_ready) begin
         if (skid_valid) begin
            out_data   <= skid_data;
            out_valid  <= 1'b1;
            skid_valid <= 1'b0;
         end else if (in_valid && in_ready) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end else if (in_valid && in_ready) begin
         // stalled: output holds, newcomer parks in the skid slot
         skid_data  <= in_data;
         skid_valid <= 1'b1;
      end
   end
endmodule

// File: rtl/nand_gate_pipe.sv
// Pipelined NUM_IN-operand bitwise gate with valid/ready on both sides,
// a skid-buffered output register and a wrapping transfer counter.
module nand_gate_pipe
   import nand_gate_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int NUM_IN = 2,
   parameter int CNT_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [NUM_IN*WIDTH-1:0] in_x,
   input  logic [OP_W-1:0]         in_op,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_z,
   output logic                    out_err,
   output logic [CNT_W-1:0]        txn_count
);
   if (NUM_IN < 2 || NUM_IN > MAX_IN) begin : g_bad_num_in
      $error("nand_gate_pipe: NUM_IN must be in 2..8");
   end

   logic [WIDTH-1:0] z_c;
   logic [WIDTH-1:0] err_c;
   logic [WIDTH:0]   out_data;

   for (genvar b = 0; b < WIDTH; b++) begin : g_bit
      logic [MAX_IN-1:0] col;
      for (genvar k = 0; k < MAX_IN; k++) begin : g_col
         if (k < NUM_IN) begin : g_used
            assign col[k] = in_x[k*WIDTH+b];
         end else begin : g_pad
            assign col[k] = 1'b0;
         end
      end
      assign {err_c[b], z_c[b]} = gate_reduce(in_op, col, NUM_IN);
   end

   nand_gate_skid #(.DW(WIDTH+1)) u_skid (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   ({|err_c, z_c}),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   assign out_err = out_data[WIDTH];
   assign out_z   = out_data[WIDTH-1:0];

   always_ff @(posedge clk) begin
      if (!rst_n)
         txn_count <= '0;
      else if (out_valid && out_ready)
         txn_count <= txn_count + CNT_W'(1);
   end
endmodule

// File: tb/tb_nand_gate_pipe.sv
// Scoreboard bench: dut_a (2 operands, 4-bit counter) carries the stream tests,
// dut_b (4 operands) covers the multi-operand reduction.
module tb_nand_gate_pipe;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_err;
   logic [15:0] in_x = '0;
   logic [2:0]  in_op = '0;
   logic [7:0]  out_z;
   logic [3:0]  txn_count;

   logic        b_valid = 1'b0, b_in_ready, b_out_valid, b_err;
   logic [31:0] b_x = '0;
   logic [2:0]  b_op = '0;
   logic [7:0]  b_z;
   logic [15:0] b_count;

   int          n_pass = 0, n_total = 0, tb_xfers = 0;
   logic [8:0]  sb[$];

   always #5 clk = ~clk;

   nand_gate_pipe #(.WIDTH(8), .NUM_IN(2), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_op(in_op), .out_valid(out_valid), .out_ready(out_ready),
      .out_z(out_z), .out_err(out_err), .txn_count(txn_count));

   nand_gate_pipe #(.WIDTH(8), .NUM_IN(4), .CNT_W(16)) dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_valid), .in_ready(b_in_ready),
      .in_x(b_x), .in_op(b_op), .out_valid(b_out_valid), .out_ready(1'b1),
      .out_z(b_z), .out_err(b_err), .txn_count(b_count));

   function automatic logic [8:0] model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      case (op)
         3'd0: return {1'b0, ~(a & b)};
         3'd1: return {1'b0, a & b};
         3'd2: return {1'b0, ~(a | b)};
         3'd3: return {1'b0, a | b};
         3'd4: return {1'b0, a ^ b};
         3'd5: return {1'b0, ~(a ^ b)};
         3'd6: return {1'b0, ~a};
         default: return {1'b1, ~(a & b)};
      endcase
   endfunction

   // Output monitor: a transfer seen at the negedge completes at the next posedge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic [8:0] e;
         n_total++;
         tb_xfers++;
         if (sb.size() == 0) begin
            $display("FAIL out_unexpected: got err=%0b z=%h, required no output", out_err, out_z);
         end else begin
            e = sb.pop_front();
            if ({out_err, out_z} !== e)
               $display("FAIL out_data: got err=%0b z=%h, required err=%0b z=%h", out_err, out_z, e[8], e[7:0]);
            else n_pass++;
         end
      end
   end

   task automatic send(input logic [2:0] op, input logic [7:0] x0, input logic [7:0] x1, input logic [8:0] e);
      int  n = 0;
      bit  got = 0;
      in_valid = 1'b1; in_op = op; in_x = {x1, x0};
      while (!got && n < 300) begin
         @(negedge clk);
         if (in_ready) got = 1; else n++;
      end
      if (got) begin
         sb.push_back(e);
         @(posedge clk); #1;
      end else begin
         n_total++;
         $display("FAIL accept_timeout: in_ready stayed %0b, required 1", in_ready);
      end
      in_valid = 1'b0;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      @(negedge clk);
      n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %0b, required 0", in_ready); else n_pass++;
      cycles(2);
      n_total++; if ({out_valid, out_err, out_z, txn_count} !== 14'd0)
         $display("FAIL rst_state: got v=%0b e=%0b z=%h c=%0d, required all 0", out_valid, out_err, out_z, txn_count);
      else n_pass++;
      n_total++; if ({b_out_valid, b_count} !== 17'd0) $display("FAIL rst_b: got v=%0b c=%0d, required 0", b_out_valid, b_count); else n_pass++;
      rst_n = 1'b1; sb.delete(); tb_xfers = 0;
      #1;
      n_total++; if (in_ready !== 1'b1) $display("FAIL post_rst_ready: got %0b, required 1", in_ready); else n_pass++;
   endtask

   task automatic test_basic;
      out_ready = 1'b1;
      send(3'd0, 8'hF0, 8'hCC, 9'h03F);
      n_total++; if (!(out_valid === 1'b1 && out_z === 8'h3F))
         $display("FAIL latency: got v=%0b z=%h, required v=1 z=3f", out_valid, out_z);
      else n_pass++;
      send(3'd4, 8'hF0, 8'hCC, 9'h03C);
      send(3'd6, 8'hF0, 8'hCC, 9'h00F);
      cycles(2);
      n_total++; if (out_valid !== 1'b0) $display("FAIL idle_valid: got %0b, required 0", out_valid); else n_pass++;
   endtask

   task automatic test_reduction;
      logic [2:0] ops [5] = '{3'd1, 3'd0, 3'd5, 3'd2, 3'd4};
      logic [7:0] exps[5] = '{8'h7F, 8'h80, 8'h7F, 8'h00, 8'h80};
      b_x = {8'h7F, 8'hFF, 8'hFF, 8'hFF};
      b_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         b_op = ops[i];
         @(posedge clk); #1;
         n_total++; if (!(b_out_valid === 1'b1 && b_z === exps[i] && b_err === 1'b0))
            $display("FAIL reduce_op%0d: got v=%0b z=%h e=%0b, required v=1 z=%h e=0", ops[i], b_out_valid, b_z, b_err, exps[i]);
         else n_pass++;
      end
      b_valid = 1'b0;
      cycles(1);
      n_total++; if (!(b_count === 16'd5 && b_out_valid === 1'b0))
         $display("FAIL reduce_count: got c=%0d v=%0b, required c=5 v=0", b_count, b_out_valid);
      else n_pass++;
   endtask

   task automatic test_reserved;
      int snap;
      out_ready = 1'b1;
      snap = tb_xfers;
      send(3'd7, 8'hAA, 8'hFF, 9'h155);
      n_total++; if (!(out_err === 1'b1 && out_z === 8'h55))
         $display("FAIL rsvd_out: got e=%0b z=%h, required e=1 z=55", out_err, out_z);
      else n_pass++;
      cycles(1);
      n_total++; if (txn_count !== 4'(snap + 1)) $display("FAIL rsvd_count: got %0d, required %0d", txn_count, 4'(snap + 1)); else n_pass++;
   endtask

   task automatic test_backpressure;
      out_ready = 1'b0;
      fork
         for (int k = 0; k < 4; k++) send(3'd3, 8'(k * 17), 8'(8'h80 >> k), model(3'd3, 8'(k * 17), 8'(8'h80 >> k)));
         begin
            cycles(4);
            n_total++; if (!(out_valid === 1'b1 && out_z === model(3'd3, 8'd0, 8'h80)))
               $display("FAIL bp_hold: got v=%0b z=%h, required v=1 z=%h", out_valid, out_z, model(3'd3, 8'd0, 8'h80));
            else n_pass++;
            n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b, required 0", in_ready); else n_pass++;
            out_ready = 1'b1;
         end
      join
      cycles(3);
      n_total++; if (sb.size() != 0) $display("FAIL bp_drain: got %0d pending, required 0", sb.size()); else n_pass++;
   endtask

   task automatic test_back_to_back;
      bit done = 0;
      fork
         begin
            for (int k = 0; k < 24; k++) begin
               logic [2:0] op = 3'($urandom_range(0, 7));
               logic [7:0] a = 8'($urandom), b = 8'($urandom);
               send(op, a, b, model(op, a, b));
            end
            done = 1;
         end
         while (!done) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
         end
      join
      out_ready = 1'b1;
      cycles(4);
      n_total++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending, required 0", sb.size()); else n_pass++;
      n_total++; if (txn_count !== 4'(tb_xfers)) $display("FAIL b2b_count: got %0d, required %0d", txn_count, 4'(tb_xfers)); else n_pass++;
   endtask

   task automatic test_reset_stall_and_wrap;
      out_ready = 1'b0;
      send(3'd0, 8'h12, 8'h34, model(3'd0, 8'h12, 8'h34));
      send(3'd1, 8'h56, 8'h78, model(3'd1, 8'h56, 8'h78));
      n_total++; if (!(out_valid === 1'b1 && in_ready === 1'b0))
         $display("FAIL stall_full: got v=%0b rdy=%0b, required v=1 rdy=0", out_valid, in_ready);
      else n_pass++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1; sb.delete(); tb_xfers = 0;
      #1;
      n_total++; if (!(out_valid === 1'b0 && in_ready === 1'b1 && txn_count === 4'd0))
         $display("FAIL mid_rst: got v=%0b rdy=%0b c=%0d, required v=0 rdy=1 c=0", out_valid, in_ready, txn_count);
      else n_pass++;
      out_ready = 1'b1;
      cycles(5);
      n_total++; if (out_valid !== 1'b0) $display("FAIL stale_out: got v=%0b, required 0", out_valid); else n_pass++;
      for (int k = 0; k < 17; k++) send(3'd4, 8'(k), 8'h5A, model(3'd4, 8'(k), 8'h5A));
      cycles(2);
      n_total++; if (txn_count !== 4'd1) $display("FAIL wrap_count: got %0d, required 1", txn_count); else n_pass++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_reduction;
      test_reserved;
      test_backpressure;
      test_back_to_back;
      test_reset_stall_and_wrap;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
